prefetch_unit: RTL

Parametrised instruction-fetch front end for the AGC pipeline core. It generates sequential ROM addresses from a program counter and tracks reads in flight through a ROM of configurable latency. Returned words are buffered, each tagged with its PC, in a DEPTH-entry queue that decode drains with a valid/ready handshake. A redirect from execute flushes the queue and cancels fetches in flight, replacing the single PC register plus flush logic of the current fetch stage.

---
 rtl/agc_pkg.sv | 14 +
 rtl/prefetch_queue.sv | 66 ++++++
 rtl/prefetch_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/agc_pkg.sv
// Shared constants and types for the AGC pipeline core front end.
package agc_pkg;

   parameter int AGC_WORD_W = 15;
   parameter int AGC_ADDR_W = 15;
   parameter logic [AGC_ADDR_W-1:0] AGC_RESET_PC = 15'o4000;

   // One fetched instruction tagged with the address it was read from.
   typedef struct packed {
      logic [AGC_ADDR_W-1:0] pc;
      logic [AGC_WORD_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/prefetch_queue.sv
// Circular buffer of fetch entries: push at the tail, pop at the head,
// flush empties it in one cycle. DEPTH must be a power of two so the
// pointers wrap naturally. The head output reads as zero while empty.
module prefetch_queue
   import agc_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = fetch_entry_t
) (
   input  logic                         clock,
   input  logic                         rst_l,
   input  logic                         i_push,
   input  entry_t                       i_data,
   input  logic                         i_pop,
   input  logic                         i_flush,
   output entry_t                       o_head,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_full,
   output logic                         o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   entry_t             r_mem [DEPTH];
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [CNT_W-1:0]   r_count;
   logic               w_do_push;
   logic               w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_count   = r_count;
   assign w_do_pop  = i_pop && !o_empty;
   // A full queue can still accept a word when the head leaves the same cycle.
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

   // Pointer and count bookkeeping; flush wins over push and pop.
   always_ff @(posedge clock or negedge rst_l) begin
      if (!rst_l) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage; contents are only meaningful between head and tail.
   always_ff @(posedge clock) begin
      if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/prefetch_unit.sv
// Instruction-fetch front end: sequential ROM reads from a fetch PC,
// in-flight tracking across ROM_LAT cycles, and a PC-tagged queue drained
// by decode (valid/ready). A redirect flushes the queue and kills fetches
// in flight.
//
// Handshakes: instr is transferred on a cycle where instr_valid and
// deq_ready are both high; instr_valid never depends on deq_ready.
//
// Optional feature macro: PREFETCH_BYPASS_EN. When defined, a return that
// arrives while the queue is empty is presented to decode combinationally
// and skips the queue if decode takes it that cycle.
module prefetch_unit
   import agc_pkg::*;
#(
   parameter int                WORD_W   = AGC_WORD_W,
   parameter int                ADDR_W   = AGC_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(AGC_RESET_PC),
   parameter int                DEPTH    = 4,
   parameter int                ROM_LAT  = 1
) (
   input  logic                         clock,
   input  logic                         rst_l,
   output logic                         rom_req,
   output logic [ADDR_W-1:0]            rom_addr,
   input  logic [WORD_W-1:0]            rom_data,
   input  logic                         redirect,
   input  logic [ADDR_W-1:0]            redirect_pc,
   output logic                         instr_valid,
   output logic [WORD_W-1:0]            instr,
   output logic [ADDR_W-1:0]            instr_pc,
   input  logic                         deq_ready,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int SUM_W = $clog2(DEPTH+ROM_LAT+1);

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [WORD_W-1:0] instr;
   } entry_t;

   logic [ADDR_W-1:0]   r_fetch_pc;
   logic                r_run;
   logic [ROM_LAT-1:0]  r_if_valid;
   logic [ADDR_W-1:0]   r_if_pc [ROM_LAT];

   logic [SUM_W-1:0]    w_if_count;
   logic [SUM_W-1:0]    w_used;
   logic                w_issue;
   logic                w_ret;
   logic                w_push;
   logic                w_pop;
   entry_t              w_push_data;
   entry_t              w_head;
   logic [CNT_W-1:0]    w_q_count;
   logic                w_q_full;
   logic                w_q_empty;

   // Number of reads issued whose data has not yet come back.
   always_comb begin
      w_if_count = '0;
      for (int i = 0; i < ROM_LAT; i++) begin
         w_if_count = w_if_count + SUM_W'(r_if_valid[i]);
      end
   end

   // Credits come from registered state only: a dequeue this cycle frees
   // a slot next cycle, which keeps every outstanding return guaranteed a slot.
   assign w_used   = SUM_W'(w_q_count) + w_if_count;
   assign w_issue  = r_run && !redirect && !w_q_full && (w_used < SUM_W'(DEPTH));
   assign rom_req  = w_issue;
   assign rom_addr = r_fetch_pc;

   // r_run holds off issue until the first edge after reset is released.
   always_ff @(posedge clock or negedge rst_l) begin
      if (!rst_l) r_run <= 1'b0;
      else        r_run <= 1'b1;
   end

   // Fetch PC: redirect target takes priority, otherwise advance on issue.
   always_ff @(posedge clock or negedge rst_l) begin
      if (!rst_l)        r_fetch_pc <= RESET_PC;
      else if (redirect) r_fetch_pc <= redirect_pc;
      else if (w_issue)  r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
   end

   // In-flight shift register; redirect kills every outstanding read.
   always_ff @(posedge clock or negedge rst_l) begin
      if (!rst_l) begin
         r_if_valid <= '0;
         for (int i = 0; i < ROM_LAT; i++) r_if_pc[i] <= '0;
      end else begin
         r_if_valid[0] <= w_issue;
         r_if_pc[0]    <= r_fetch_pc;
         for (int i = 1; i < ROM_LAT; i++) begin
            r_if_valid[i] <= r_if_valid[i-1];
            r_if_pc[i]    <= r_if_pc[i-1];
         end
         if (redirect) r_if_valid <= '0;
      end
   end

   // A return in the redirect cycle belongs to the old stream and is dropped.
   assign w_ret             = r_if_valid[ROM_LAT-1] && !redirect;
   assign w_push_data.pc    = r_if_pc[ROM_LAT-1];
   assign w_push_data.instr = rom_data;

`ifdef PREFETCH_BYPASS_EN
   logic w_byp;
   assign w_byp       = w_q_empty && w_ret;
   assign w_push      = w_ret && !(w_byp && deq_ready);
   assign instr_valid = !w_q_empty || w_byp;
   assign instr       = w_byp ? rom_data : w_head.instr;
   assign instr_pc    = w_byp ? r_if_pc[ROM_LAT-1] : w_head.pc;
`else
   assign w_push      = w_ret;
   assign instr_valid = !w_q_empty;
   assign instr       = w_head.instr;
   assign instr_pc    = w_head.pc;
`endif

   // Only a stored head is popped; a bypassed word never entered the queue.
   assign w_pop     = instr_valid && deq_ready && !w_q_empty;
   assign occupancy = w_q_count;

   prefetch_queue #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_queue (
      .clock   (clock),
      .rst_l   (rst_l),
      .i_push  (w_push),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .i_flush (redirect),
      .o_head  (w_head),
      .o_count (w_q_count),
      .o_full  (w_q_full),
      .o_empty (w_q_empty)
   );

endmodule
